// File: rtl/hub75_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hub75_pkg
// Description : Shared state encodings, row-select modes and the BCM timer
//               width helper for the HUB75 scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
package hub75_pkg;

    localparam int c_STATE_W = 3;

    localparam logic [c_STATE_W-1:0] c_ST_IDLE       = 3'd0;
    localparam logic [c_STATE_W-1:0] c_ST_START      = 3'd1;
    localparam logic [c_STATE_W-1:0] c_ST_WAIT_SHIFT = 3'd2;
    localparam logic [c_STATE_W-1:0] c_ST_LATCH      = 3'd3;
    localparam logic [c_STATE_W-1:0] c_ST_DRAIN      = 3'd4;

    localparam int c_ROW_MODE_SHIFT = 0;
    localparam int c_ROW_MODE_PAR   = 1;

    // Wide enough to hold the longest plane period, BASE_CYCLES << (BITS-1).
    function automatic int timer_width(input int base_cycles, input int bits);
        return $clog2(base_cycles << (bits - 1)) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hub75_bcm_timer.sv
`default_nettype none
// ============================================================================
// Module      : hub75_bcm_timer
// Description : Bit-plane display timer; counts a loaded period down to zero
//               and derives the brightness-scaled blank window.
// Revision    : 1.0 - initial release
// ============================================================================
module hub75_bcm_timer #(
    parameter int TIMER_W = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [TIMER_W-1:0] period,
    input  logic [7:0]         bright_q,
    output logic               zero,
    output logic               blank
);

    logic [TIMER_W+7:0] w_prod;
    logic [TIMER_W-1:0] w_on;
    logic [TIMER_W-1:0] w_thresh;
    logic [TIMER_W-1:0] r_timer;
    logic [TIMER_W-1:0] r_thresh;

    // On-time is (period * bright_q) >> 8, so 255 never reaches the full period.
    assign w_prod   = {8'd0, period} * {{TIMER_W{1'b0}}, bright_q};
    assign w_on     = TIMER_W'(w_prod >> 8);
    assign w_thresh = period - w_on;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timer  <= '0;
            r_thresh <= '0;
        end else if (load) begin
            r_timer  <= period;
            r_thresh <= w_thresh;
        end else if (r_timer != '0) begin
            r_timer  <= r_timer - TIMER_W'(1);
        end
    end

    assign zero  = (r_timer == '0);
    assign blank = !(r_timer > r_thresh);

endmodule
`default_nettype wire

// File: rtl/hub75_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hub75_scan_ctrl
// Description : HUB75 row x bit-plane scan sequencer with overlapped shift and
//               display, global brightness duty and row-select generation.
//               Optional frame-buffer swap handshake: define HUB75_SWAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module hub75_scan_ctrl
    import hub75_pkg::*;
#(
    parameter  int ROWS        = 32,
    parameter  int BITS        = 8,
    parameter  int BASE_CYCLES = 64,
    parameter  int LAT_CYCLES  = 2,
    parameter  int ROW_MODE    = 0,
    localparam int c_ROW_W     = $clog2(ROWS),
    localparam int c_BIT_W     = (BITS > 1) ? $clog2(BITS) : 1
) (
`ifdef HUB75_SWAP_EN
    input  logic               swap_req,
    output logic               swap_ack,
`endif
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [7:0]         brightness,
    input  logic               fetchshift_busy,
    output logic               fetchshift_start,
    output logic [c_BIT_W-1:0] bit_out,
    output logic [c_ROW_W-1:0] row_out,
    output logic               frame_start,
    output logic               lat,
    output logic               blank,
    output logic               row_clk,
    output logic               row_data,
    output logic [c_ROW_W-1:0] row_addr
);

    localparam int c_TIMER_W = timer_width(BASE_CYCLES, BITS);
    localparam int c_LAT_W   = $clog2(LAT_CYCLES + 1);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_nxt;
    logic [c_ROW_W-1:0]   r_row;
    logic [c_BIT_W-1:0]   r_bit;
    logic [c_LAT_W-1:0]   r_lat_cnt;
    logic                 r_first;
    logic [7:0]           r_bright_q;
    logic                 w_frame;
    logic                 w_last_lat;
    logic                 w_row_upd;
    logic                 w_load;
    logic                 w_timer_zero;
    logic [c_TIMER_W-1:0] w_period;

    assign w_frame    = (r_state == c_ST_START) && (r_row == '0) && (r_bit == '0);
    assign w_last_lat = (r_state == c_ST_LATCH) && (r_lat_cnt == c_LAT_W'(LAT_CYCLES));
    assign w_row_upd  = (r_state == c_ST_LATCH) && (r_lat_cnt == '0);
    assign w_load     = w_last_lat;
    assign w_period   = c_TIMER_W'(BASE_CYCLES) << r_bit;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:       if (enable) w_state_nxt = c_ST_START;
            c_ST_START:      w_state_nxt = c_ST_WAIT_SHIFT;
            // Busy is not yet valid in the cycle right after the start pulse.
            c_ST_WAIT_SHIFT: if (!r_first && !fetchshift_busy && w_timer_zero)
                                 w_state_nxt = c_ST_LATCH;
            c_ST_LATCH:      if (w_last_lat)
                                 w_state_nxt = enable ? c_ST_START : c_ST_DRAIN;
            c_ST_DRAIN:      if (w_timer_zero) w_state_nxt = c_ST_IDLE;
            default:         w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= c_ST_IDLE;
            r_row      <= '0;
            r_bit      <= '0;
            r_lat_cnt  <= '0;
            r_first    <= 1'b0;
            r_bright_q <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_first <= (r_state == c_ST_START);
            if ((r_state == c_ST_LATCH) && !w_last_lat)
                r_lat_cnt <= r_lat_cnt + c_LAT_W'(1);
            else
                r_lat_cnt <= '0;
            if (w_frame)
                r_bright_q <= brightness;
            if (w_load) begin
                if (r_bit == c_BIT_W'(BITS - 1)) begin
                    r_bit <= '0;
                    r_row <= r_row + c_ROW_W'(1);
                end else begin
                    r_bit <= r_bit + c_BIT_W'(1);
                end
            end
        end
    end

    assign fetchshift_start = (r_state == c_ST_START);
    assign frame_start      = w_frame;
    assign bit_out          = r_bit;
    assign row_out          = r_row;
    assign lat              = (r_state == c_ST_LATCH) && (r_lat_cnt != '0);

    hub75_bcm_timer #(
        .TIMER_W (c_TIMER_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .period   (w_period),
        .bright_q (r_bright_q),
        .zero     (w_timer_zero),
        .blank    (blank)
    );

    generate
        if (ROW_MODE == c_ROW_MODE_PAR) begin : g_row_par
            logic [c_ROW_W-1:0] r_row_addr;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    r_row_addr <= '0;
                else if (w_row_upd)
                    r_row_addr <= r_row;
            end

            assign row_addr = r_row_addr;
            assign row_clk  = 1'b0;
            assign row_data = 1'b0;
        end else begin : g_row_shift
            logic [c_ROW_W-1:0] r_disp_row;
            logic               r_row_valid;
            logic               r_row_clk;
            logic               r_row_data;
            logic               w_step;

            // The first latch after reset always clocks, so the external
            // shift register is never assumed to hold a known row.
            assign w_step = w_row_upd && (!r_row_valid || (r_disp_row != r_row));

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_disp_row  <= '0;
                    r_row_valid <= 1'b0;
                    r_row_clk   <= 1'b0;
                    r_row_data  <= 1'b0;
                end else begin
                    r_row_clk  <= w_step;
                    r_row_data <= w_step && (r_row == '0);
                    if (w_row_upd) begin
                        r_disp_row  <= r_row;
                        r_row_valid <= 1'b1;
                    end
                end
            end

            assign row_clk  = r_row_clk;
            assign row_data = r_row_data;
            assign row_addr = '0;
        end
    endgenerate

`ifdef HUB75_SWAP_EN
    assign swap_ack = w_frame && swap_req;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hub75_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hub75_scan_ctrl
// Description : Self-checking bench for hub75_scan_ctrl (4 rows, 2 planes).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hub75_scan_ctrl;

    localparam int c_ROWS = 4;
    localparam int c_BITS = 2;
    localparam int c_BASE = 8;
    localparam int c_LATC = 2;
    localparam int c_NPL  = c_ROWS * c_BITS;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] brightness = 8'd0;
    logic       busy = 1'b0;
    logic       fs_start, frame_start, lat, blank, row_clk, row_data;
    logic [0:0] bit_out;
    logic [1:0] row_out, row_addr;
`ifdef HUB75_SWAP_EN
    logic       swap_req = 1'b0;
    logic       swap_ack;
    int         acks = 0;
`endif

    int tests = 0;
    int fails = 0;
    int busy_len = 3;
    int bcnt = 0;

    // reference model state
    int p, q, mdisp, k, on, per, latrun, pulses, mbq, frames;
    bit in_win, prev_lat;

    always #5 clk = ~clk;

    hub75_scan_ctrl #(
        .ROWS(c_ROWS), .BITS(c_BITS), .BASE_CYCLES(c_BASE),
        .LAT_CYCLES(c_LATC), .ROW_MODE(0)
    ) dut (
`ifdef HUB75_SWAP_EN
        .swap_req(swap_req), .swap_ack(swap_ack),
`endif
        .clk(clk), .rst(rst), .enable(enable), .brightness(brightness),
        .fetchshift_busy(busy), .fetchshift_start(fs_start),
        .bit_out(bit_out), .row_out(row_out), .frame_start(frame_start),
        .lat(lat), .blank(blank), .row_clk(row_clk), .row_data(row_data),
        .row_addr(row_addr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Fetch/shift engine: busy for busy_len cycles after each start.
    always @(posedge clk) begin
        #2;
        if (!rst) begin
            busy = 1'b0;
            bcnt = 0;
        end else if (bcnt > 0) begin
            bcnt--;
            if (bcnt == 0) busy = 1'b0;
        end else if (fs_start) begin
            busy = 1'b1;
            bcnt = busy_len;
        end
    end

    // Plane-level model: start order, display window duty, lat width, row select.
    always @(negedge clk) begin
        if (!rst) begin
            p = 0; q = 0; mdisp = -1; k = 0; on = 0; per = 0;
            latrun = 0; mbq = 0; in_win = 0; prev_lat = 0;
        end else begin
            if (prev_lat && !lat) begin
                check("lat_width", latrun, c_LATC);
                per = c_BASE << (q % c_BITS);
                on = (per * mbq) >> 8;
                in_win = 1; k = 0; q++;
            end
            check("blank", blank, (in_win && k < on) ? 0 : 1);
            if (in_win) begin
                k++;
                if (k == per) in_win = 0;
            end
            if (lat && !prev_lat) begin
                check("busy_at_lat", busy, 0);
                check("row_clk_step", row_clk, (mdisp != (q / c_BITS) % c_ROWS));
                if (mdisp != (q / c_BITS) % c_ROWS)
                    check("row_data", row_data, ((q / c_BITS) % c_ROWS) == 0);
                pulses += row_clk;
                mdisp = (q / c_BITS) % c_ROWS;
            end else begin
                check("row_clk_idle", row_clk, 0);
                check("row_data_idle", row_data, 0);
            end
            latrun = lat ? latrun + 1 : 0;
            if (fs_start) begin
                check("row_out", row_out, (p / c_BITS) % c_ROWS);
                check("bit_out", bit_out, p % c_BITS);
                check("frame_start", frame_start, (p % c_NPL) == 0);
`ifdef HUB75_SWAP_EN
                check("swap_ack_frame", swap_ack, ((p % c_NPL) == 0) && swap_req);
`endif
                if ((p % c_NPL) == 0) begin
                    mbq = brightness;
                    frames++;
                end
                p++;
            end else begin
                check("frame_idle", frame_start, 0);
`ifdef HUB75_SWAP_EN
                check("swap_ack_idle", swap_ack, 0);
`endif
            end
`ifdef HUB75_SWAP_EN
            acks += swap_ack;
`endif
            check("row_addr", row_addr, 0);
            prev_lat = lat;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic at_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_planes(input int target);
        int n = 0;
        while (q < target && n < 3000) begin tick(); n++; end
        if (q < target) check("wait_planes_timeout", q, target);
    endtask

    task automatic wait_start();
        int p0 = p;
        int n = 0;
        while (p == p0 && n < 3000) begin tick(); n++; end
        if (p == p0) check("wait_start_timeout", p, p0 + 1);
    endtask

    task automatic wait_frame();
        int f0 = frames;
        int n = 0;
        while (frames == f0 && n < 3000) begin tick(); n++; end
        if (frames == f0) check("wait_frame_timeout", frames, f0 + 1);
    endtask

    initial begin
        int snap, lows, n;
        frames = 0;
        pulses = 0;
        repeat (3) tick();
        check("rst_blank", blank, 1);
        check("rst_lat", lat, 0);
        check("rst_start", fs_start, 0);
        check("rst_frame", frame_start, 0);
        check("rst_row_out", row_out, 0);
        check("rst_bit_out", bit_out, 0);
        check("rst_row_clk", row_clk, 0);
        check("rst_row_data", row_data, 0);
        check("rst_row_addr", row_addr, 0);

        at_pos();
        rst = 1'b1; brightness = 8'd128; enable = 1'b1;
        wait_planes(8);
        check("row_clk_frame0", pulses, c_ROWS);
        snap = pulses;
        wait_planes(16);
        check("row_clk_frame1", pulses - snap, c_ROWS);

        for (int i = 0; i < 4; i++) begin
            at_pos();
            brightness = (i == 0) ? 8'd255 : 8'($urandom_range(0, 255));
            busy_len = $urandom_range(1, 6);
            wait_planes(q + 5);
        end

        at_pos();
        brightness = 8'd0; busy_len = 3;
        wait_frame();
        wait_planes(q + 1);
        lows = 0; n = 0; snap = frames;
        while (frames == snap && n < 600) begin
            if (!blank) lows++;
            tick(); n++;
        end
        check("bright0_lows", lows, 0);
        check("bright0_frame_end", frames, snap + 1);

        at_pos();
        brightness = 8'd200; busy_len = 40;
        wait_start();
        repeat (30) tick();
        check("slow_blank", blank, 1);
        check("slow_lat", lat, 0);
        wait_planes(q + 3);
        busy_len = 3;

        wait_start();
        at_pos();
        enable = 1'b0;
        repeat (100) tick();
        snap = p;
        repeat (30) tick();
        check("idle_no_start", p, snap);
        check("drained", q, p);
        check("idle_blank", blank, 1);
        at_pos();
        enable = 1'b1;
        wait_start();
        check("resume_one_start", p, snap + 1);
        wait_planes(q + 4);

`ifdef HUB75_SWAP_EN
        at_pos();
        swap_req = 1'b1;
        snap = acks;
        wait_frame();
        check("swap_first_ack", acks, snap + 1);
        wait_frame();
        check("swap_second_ack", acks, snap + 2);
        swap_req = 1'b0;
`endif

        n = 0;
        while (!lat && n < 500) begin tick(); n++; end
        check("lat_seen", lat, 1);
        #2 rst = 1'b0;
        #1;
        check("arst_lat", lat, 0);
        check("arst_blank", blank, 1);
        check("arst_start", fs_start, 0);
        repeat (3) tick();
        at_pos();
        rst = 1'b1; brightness = 8'($urandom_range(1, 255));
        wait_planes(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/hub75_scan_ctrl.md
Name: hub75_scan_ctrl

Overview:
- Parametrised successor to the HUB75 main scan FSM.
- Sequences row × bit-plane scanning for any scan-row count and bit depth.
- Overlaps shifting of the next plane with display of the current one through a start/busy handshake to the fetch/shift engine.
- Adds a global brightness duty on blank, a selectable row-select mode (shift register or parallel address) and a frame-boundary pulse.

Parameters:
- ROWS, 32, scan rows per panel (power of two, 2..64); ROW_W = $clog2(ROWS).
- BITS, 8, bit planes per colour (1..10); BIT_W = $clog2(BITS), minimum 1.
- BASE_CYCLES, 64, display period of bit 0 in clk cycles; bit b period = BASE_CYCLES << b.
- LAT_CYCLES, 2, lat high width in cycles (≥1).
- ROW_MODE, 0, 0 = shift-register row select (row_clk/row_data); 1 = parallel row_addr.

Ports:
- clk in 1: system clock.
- rst in 1: asynchronous, active-low reset.
- enable in 1: scan run request.
- brightness in 8: global duty, sampled at frame start.
- fetchshift_busy in 1: fetch/shift engine busy.
- fetchshift_start out 1: 1-cycle pulse, begin shifting plane (row_out, bit_out).
- bit_out out BIT_W: bit index of plane being shifted.
- row_out out ROW_W: row index of plane being shifted.
- frame_start out 1: 1-cycle pulse with the start for row 0, bit 0.
- lat out 1: panel latch.
- blank out 1: panel output disable (1 = dark).
- row_clk out 1: row shift clock (ROW_MODE 0; held 0 otherwise).
- row_data out 1: row shift data (ROW_MODE 0; held 0 otherwise).
- row_addr out ROW_W: displayed row (ROW_MODE 1; held 0 otherwise).
- swap_req in 1 / swap_ack out 1: present only with HUB75_SWAP_EN.

Behaviour:
- Reset:
  - blank = 1; all other outputs 0.
  - State IDLE; counters row = 0, bit = 0.
  - Timer and brightness latch cleared.
- Scan order: for row 0..ROWS-1, for bit 0..BITS-1; wraps to row 0, bit 0.
- States and transitions:
  - IDLE → START: when enable = 1.
  - START: assert fetchshift_start for 1 cycle with current row_out/bit_out.
    - frame_start asserts in the same cycle when row = bit = 0.
    - At a frame start, brightness is latched into bright_q.
    - → WAIT_SHIFT.
  - WAIT_SHIFT: fetchshift_busy is ignored in the first cycle after start; the engine must raise it by then.
    - Leave when busy = 0 and the display timer = 0 → LATCH.
  - LATCH:
    - blank = 1 on entry.
    - Next cycle: lat = 1 for LAT_CYCLES.
    - On the first lat cycle the displayed row updates: ROW_MODE 1 loads row_addr; ROW_MODE 0 pulses row_clk 1 cycle when the row changes, with row_data = 1 iff the new displayed row is 0.
    - After lat falls: load timer = BASE_CYCLES << bit; blank = 0 if bright_q ≠ 0.
    - Advance the row/bit counters.
    - → START if enable, else → DRAIN.
- Display timer (overlaps the next shift):
  - Counts down to 0.
  - blank deasserts while timer > period − ((period × bright_q) >> 8), reasserting for the remainder.
  - bright_q = 0 → blank permanently 1; bright_q = 255 → on-time is 255/256 of the period, truncated.
  - Timer width = ROW-independent, $clog2(BASE_CYCLES << (BITS-1)) + 1; the product is computed at full width before the shift.
- DRAIN: wait for the timer = 0, then blank = 1 → IDLE; the counters hold, so a later enable resumes at the next plane.
- Asynchronous reset mid-plane forces blank = 1 immediately and aborts any lat pulse.
- A new brightness value mid-frame has no effect until the next frame_start.

Optional Feature:
- HUB75_SWAP_EN defined:
  - swap_req is sampled in the cycle frame_start would assert.
  - If high, swap_ack pulses 1 cycle coincident with frame_start; the framebuffer side flips the display buffer on swap_ack.
  - swap_req held high yields one ack per frame.
- Undefined: swap ports absent, no swap logic.

Decomposition:
- Package hub75_pkg:
  - state enum (IDLE, START, WAIT_SHIFT, LATCH, DRAIN);
  - width helper function for the timer;
  - ROW_MODE_SHIFT/ROW_MODE_PAR constants.
- Sub-module hub75_bcm_timer: loads the period, counts down, produces the blank-duty compare from bright_q.

Test Plan:
- ROWS = 4, BITS = 2, BASE_CYCLES = 8, brightness = 128, busy pulse of 3 cycles after each start → start sequence (r0b0, r0b1, r1b0, …) with frame_start on every 8th start; bit 1 displays 16 cycles with blank low for the first 8.
- brightness = 0 → blank never deasserts; lat and row sequencing unchanged.
- Slow shift, busy held 40 cycles vs an 8-cycle display → the next LATCH waits for busy to fall; blank is high during the wait.
- ROW_MODE 0 over one full frame → exactly 4 row_clk pulses; row_data = 1 only on the pulse that selects row 0.
- enable dropped mid-plane → the current plane completes, blank = 1, then IDLE; re-enable resumes at the following row/bit.
- HUB75_SWAP_EN with swap_req raised mid-frame → a single swap_ack at the next frame_start and none before; rst low mid-lat → lat = 0 and blank = 1 asynchronously.
